// File: rtl/mem_if_pkg.sv
// Shared definitions for the data-memory load/store interface.
// Holds the funct3-style access size codes and the responder state type.
package mem_if_pkg;

  localparam logic [2:0] MEM_SIZE_BYTE   = 3'b000;
  localparam logic [2:0] MEM_SIZE_HALF   = 3'b001;
  localparam logic [2:0] MEM_SIZE_WORD   = 3'b010;
  localparam logic [2:0] MEM_SIZE_BYTE_U = 3'b100;
  localparam logic [2:0] MEM_SIZE_HALF_U = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } rsp_state_e;

endpackage

// File: rtl/mem_lane_steer.sv
// mem_lane_steer: combinational byte-lane steering for a 32-bit word memory.
// Ports:
//   size_i     access size code (funct3 encoding)
//   addr_lo_i  low two bits of the byte address
//   wdata_i    right-justified store data
//   rword_i    full word read from the array
//   be_o       per-byte write enables (zero for illegal sizes)
//   wword_o    store data shifted into its byte lanes
//   rdata_o    selected lanes right-justified, zero-filled above the size
//   misalign_o halfword with addr[0]=1 or word with addr[1:0]!=0
//   illegal_o  size code is not one of the five legal encodings
// Misaligned halfword/word accesses are steered as if the offending low
// address bits were zero; the caller decides whether to trap instead.
module mem_lane_steer
  import mem_if_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wword_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o,
  output logic        illegal_o
);

  logic [1:0]  lane;
  logic [3:0]  be_base;
  logic [31:0] mask;
  logic [31:0] rshift;

  always_comb begin
    lane       = 2'b00;
    be_base    = 4'b0000;
    mask       = 32'h0000_0000;
    misalign_o = 1'b0;
    illegal_o  = 1'b0;
    case (size_i)
      MEM_SIZE_BYTE, MEM_SIZE_BYTE_U: begin
        lane    = addr_lo_i;
        be_base = 4'b0001;
        mask    = 32'h0000_00FF;
      end
      MEM_SIZE_HALF, MEM_SIZE_HALF_U: begin
        lane       = {addr_lo_i[1], 1'b0};
        be_base    = 4'b0011;
        mask       = 32'h0000_FFFF;
        misalign_o = addr_lo_i[0];
      end
      MEM_SIZE_WORD: begin
        lane       = 2'b00;
        be_base    = 4'b1111;
        mask       = 32'hFFFF_FFFF;
        misalign_o = (addr_lo_i != 2'b00);
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
    // Lane index times eight gives the bit offset of the lowest byte.
    be_o    = be_base << lane;
    wword_o = wdata_i << {lane, 3'b000};
    rshift  = rword_i >> {lane, 3'b000};
    rdata_o = rshift & mask;
  end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: stalling data memory for the core's load/store port.
// One request at a time over valid/ready; the access happens LATENCY wait
// states after acceptance and the response is held until rsp_ready.
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (byte address wraps modulo 4*DEPTH)
//   LATENCY      wait states between accept and response, 0..15
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   req_valid / req_ready   request handshake (ready only in IDLE)
//   req_write, req_size     store flag and funct3 size code
//   req_addr, req_wdata     byte address and right-justified store data
//   rsp_valid / rsp_ready   response handshake
//   rsp_rdata, rsp_error    load data (0 for stores/errors) and error flag
// Build option: define MISALIGN_TRAP_EN to report misaligned halfword/word
// accesses as errors; otherwise the low address bits are forced to zero.
module data_mem_responder
  import mem_if_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  rsp_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;
  logic        write_q;
  logic [2:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        capture;
  logic        do_access;

  // With LATENCY=0 the access happens in the accept cycle, so the access
  // operands come straight from the request bus while in IDLE.
  logic        acc_write;
  logic [2:0]  acc_size;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        acc_err;
  logic [IDX_W-1:0] idx;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rword;
  logic [31:0] wr_merge;

  logic [3:0]  be;
  logic [31:0] wword;
  logic [31:0] steer_rdata;
  logic        misalign;
  logic        illegal;

  assign acc_write = (state_q == IDLE) ? req_write : write_q;
  assign acc_size  = (state_q == IDLE) ? req_size  : size_q;
  assign acc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;

  assign idx   = IDX_W'(acc_addr[31:2] % 30'(DEPTH_WORDS));
  assign rword = mem[idx];

  mem_lane_steer u_steer (
    .size_i     (acc_size),
    .addr_lo_i  (acc_addr[1:0]),
    .wdata_i    (acc_wdata),
    .rword_i    (rword),
    .be_o       (be),
    .wword_o    (wword),
    .rdata_o    (steer_rdata),
    .misalign_o (misalign),
    .illegal_o  (illegal)
  );

`ifdef MISALIGN_TRAP_EN
  assign acc_err = illegal | misalign;
`else
  logic unused_misalign;
  assign unused_misalign = misalign;
  assign acc_err = illegal;
`endif

  // Merge the enabled store lanes over the current word contents.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign wr_merge[gi*8 +: 8] = be[gi] ? wword[gi*8 +: 8] : rword[gi*8 +: 8];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    error_d   = error_q;
    capture   = 1'b0;
    do_access = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          capture = 1'b1;
          if (LATENCY == 0) begin
            state_d   = RESP;
            do_access = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d   = RESP;
          do_access = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (do_access) begin
      error_d = acc_err;
      rdata_d = (acc_write || acc_err) ? 32'h0 : steer_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      error_q <= 1'b0;
      write_q <= 1'b0;
      size_q  <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
      if (capture) begin
        write_q <= req_write;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  // Array is not reset; a reset cycle suppresses any pending write.
  always_ff @(posedge clk) begin
    if (!reset && do_access && acc_write && !acc_err) begin
      mem[idx] <= wr_merge;
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_error = error_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int LAT = 2;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_size = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  logic        z_req_valid = 1'b0;
  logic        z_req_ready;
  logic        z_req_write = 1'b0;
  logic [2:0]  z_req_size = 3'b010;
  logic [31:0] z_req_addr = 32'h0;
  logic [31:0] z_req_wdata = 32'h0;
  logic        z_rsp_valid;
  logic        z_rsp_ready = 1'b0;
  logic [31:0] z_rsp_rdata;
  logic        z_rsp_error;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
  );

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
    .req_size(z_req_size), .req_addr(z_req_addr), .req_wdata(z_req_wdata),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
    .rsp_rdata(z_rsp_rdata), .rsp_error(z_rsp_error)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int hs_count = 0;
  int pops_done = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          due;
  } exp_t;
  exp_t exp_q[$];

  // Byte-addressed reference memory, 4*DEPTH_WORDS bytes, little-endian.
  logic [7:0] mem_b [0:1023];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int nbytes(input logic [2:0] sz);
    if (sz[1:0] == 2'b00) return 1;
    if (sz[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic is_err(input logic [2:0] sz, input logic [31:0] a);
    bit legal;
    bit mis;
    legal = (sz == 3'd0) || (sz == 3'd1) || (sz == 3'd2) || (sz == 3'd4) || (sz == 3'd5);
    mis   = (a % nbytes(sz)) != 0;
    return !legal || (TRAP && mis);
  endfunction

  function automatic int base_of(input logic [2:0] sz, input logic [31:0] a);
    int b;
    b = int'(a % 1024);
    return b - (b % nbytes(sz));
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] sz, input logic [31:0] a);
    logic [31:0] r;
    int b;
    r = 32'h0;
    b = base_of(sz, a);
    for (int i = 0; i < nbytes(sz); i++) r = r | (32'(mem_b[b + i]) << (8 * i));
    return r;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!reset && rsp_valid && rsp_ready) hs_count++;
  end

  // Compare process: every cycle out of reset, the DUT's handshake outputs
  // and response payload are checked against the outstanding-request model.
  always @(negedge clk) begin
    bit exp_v;
    bit exp_r;
    if (reset) begin
      exp_q.delete();
      pops_done = hs_count;
    end else begin
      while (pops_done < hs_count) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        pops_done++;
      end
      exp_v = (exp_q.size() > 0) && (cyc >= exp_q[0].due);
      exp_r = (exp_q.size() == 0) || (cyc < exp_q[0].acc);
      check32("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_v});
      check32("req_ready", {31'b0, req_ready}, {31'b0, exp_r});
      if (exp_v && rsp_valid) begin
        check32("rsp_rdata", rsp_rdata, exp_q[0].rdata);
        check32("rsp_error", {31'b0, rsp_error}, {31'b0, exp_q[0].err});
      end
    end
  end

  task automatic xfer(input bit w, input logic [2:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, input int stall,
                      output logic [31:0] got_d, output logic got_e, output int lat);
    exp_t e;
    bit ok;
    got_d = 32'hx;
    got_e = 1'bx;
    lat   = -1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL req_wait: req_ready never rose, expected 1");
      return;
    end
    e.err   = is_err(sz, a);
    e.rdata = (w || e.err) ? 32'h0 : model_read(sz, a);
    e.acc   = cyc + 1;
    e.due   = cyc + 1 + LAT;
    exp_q.push_back(e);
    req_valid = 1'b1; req_write = w; req_size = sz; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL rsp_wait: rsp_valid never rose, expected 1");
      return;
    end
    got_d = rsp_rdata;
    got_e = rsp_error;
    lat   = cyc - e.acc + 1;
    repeat (stall) @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    if (w && !e.err) begin
      for (int i = 0; i < nbytes(sz); i++) mem_b[base_of(sz, a) + i] = wd[8*i +: 8];
    end
    $display("xfer w=%0d size=%b addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
             w, sz, a, wd, got_d, got_e, lat);
  endtask

  task automatic zxfer(input bit w, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] got_d);
    @(negedge clk);
    check32("z_req_ready", {31'b0, z_req_ready}, 32'd1);
    z_req_valid = 1'b1; z_req_write = w; z_req_size = 3'b010; z_req_addr = a; z_req_wdata = wd;
    @(posedge clk);
    #1 z_req_valid = 1'b0;
    @(negedge clk);
    check32("z_rsp_valid_T1", {31'b0, z_rsp_valid}, 32'd1);
    check32("z_rsp_error", {31'b0, z_rsp_error}, 32'd0);
    got_d = z_rsp_rdata;
    z_rsp_ready = 1'b1;
    @(posedge clk);
    #1 z_rsp_ready = 1'b0;
    @(negedge clk);
    check32("z_req_ready_after", {31'b0, z_req_ready}, 32'd1);
    check32("z_rsp_valid_after", {31'b0, z_rsp_valid}, 32'd0);
    $display("zxfer w=%0d addr=%h wdata=%h -> rdata=%h", w, a, wd, got_d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        er;
    int          lat;
    exp_t        e;

    for (int i = 0; i < 1024; i++) mem_b[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check32("reset_rdata", rsp_rdata, 32'h0);
    check32("reset_error", {31'b0, rsp_error}, 32'd0);
    check32("reset_ready", {31'b0, req_ready}, 32'd1);

    // Word store then load, latency pinned
    xfer(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, d, er, lat);
    check32("st_word_err", {31'b0, er}, 32'd0);
    check32("st_word_lat", 32'(lat), 32'd3);
    xfer(1'b0, 3'b010, 32'h10, 32'h0, 0, d, er, lat);
    check32("ld_word", d, 32'hDEADBEEF);

    // Byte store into a known word
    xfer(1'b1, 3'b010, 32'h10, 32'h11223344, 0, d, er, lat);
    xfer(1'b1, 3'b000, 32'h13, 32'h000000AA, 0, d, er, lat);
    xfer(1'b0, 3'b010, 32'h10, 32'h0, 0, d, er, lat);
    check32("ld_word_after_byte", d, 32'hAA223344);
    xfer(1'b0, 3'b100, 32'h13, 32'h0, 0, d, er, lat);
    check32("ld_bu_13", d, 32'h000000AA);
    xfer(1'b0, 3'b000, 32'h12, 32'h0, 0, d, er, lat);
    check32("ld_b_12", d, 32'h00000022);

    // Halfwords, aligned and misaligned
    xfer(1'b0, 3'b001, 32'h12, 32'h0, 0, d, er, lat);
    check32("ld_half_12", d, 32'h0000AA22);
    xfer(1'b0, 3'b101, 32'h10, 32'h0, 0, d, er, lat);
    check32("ld_hu_10", d, 32'h00003344);
    xfer(1'b0, 3'b001, 32'h11, 32'h0, 0, d, er, lat);
    check32("ld_half_11", d, TRAP ? 32'h0 : 32'h00003344);
    check32("ld_half_11_err", {31'b0, er}, TRAP ? 32'd1 : 32'd0);
    xfer(1'b0, 3'b010, 32'h13, 32'h0, 0, d, er, lat);

    // Illegal sizes: error, no write
    xfer(1'b1, 3'b011, 32'h10, 32'hFFFFFFFF, 0, d, er, lat);
    check32("illegal_st_err", {31'b0, er}, 32'd1);
    xfer(1'b0, 3'b110, 32'h10, 32'h0, 0, d, er, lat);
    check32("illegal_ld_rdata", d, 32'h0);
    xfer(1'b0, 3'b010, 32'h10, 32'h0, 0, d, er, lat);
    check32("word_unchanged", d, 32'hAA223344);

    // Misaligned word store: trapped or forced to the aligned word
    xfer(1'b1, 3'b010, 32'h16, 32'h01020304, 0, d, er, lat);
    xfer(1'b0, 3'b010, 32'h14, 32'h0, 0, d, er, lat);

    // Backpressure: held for five cycles
    xfer(1'b0, 3'b010, 32'h10, 32'h0, 5, d, er, lat);
    check32("stall_rdata", d, 32'hAA223344);

    // Address wraps modulo 1024 bytes
    xfer(1'b0, 3'b010, 32'h0000_0410, 32'h0, 0, d, er, lat);
    check32("wrap_ld", d, 32'hAA223344);

    // Reset in WAIT discards the pending store
    xfer(1'b1, 3'b010, 32'h20, 32'h12345678, 0, d, er, lat);
    @(negedge clk);
    e.err = 1'b0; e.rdata = 32'h0; e.acc = cyc + 1; e.due = cyc + 1 + LAT;
    exp_q.push_back(e);
    req_valid = 1'b1; req_write = 1'b1; req_size = 3'b000; req_addr = 32'h20; req_wdata = 32'h55;
    @(posedge clk);
    #1 req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check32("ready_after_reset", {31'b0, req_ready}, 32'd1);
    repeat (5) @(negedge clk);
    $display("xfer w=1 size=000 addr=00000020 wdata=00000055 -> dropped by reset");
    xfer(1'b0, 3'b010, 32'h20, 32'h0, 0, d, er, lat);
    check32("old_after_reset", d, 32'h12345678);

    // Zero-latency instance
    zxfer(1'b1, 32'h40, 32'hCAFEF00D, d);
    zxfer(1'b0, 32'h40, 32'h0, d);
    check32("z_ld_word", d, 32'hCAFEF00D);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
